// File: rtl/match_report_queue.sv
// Match-vector queue: tags qualified engine matches with their byte offset and
// serializes them one engine per report. Optional drop counter: MATCH_DROP_CNT_EN.
module match_report_queue #(
    parameter int MATCH_LAT  = 2,
    parameter int FIFO_DEPTH = 8,
    parameter int OFS_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sod,
    input  logic             en,
    input  logic [7:0]       match,
    output logic             rpt_valid,
    input  logic             rpt_ready,
    output logic [2:0]       rpt_id,
    output logic [OFS_W-1:0] rpt_ofs,
    output logic             overflow,
    output logic             busy
`ifdef MATCH_DROP_CNT_EN
    ,
    output logic [15:0]      drop_cnt
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [OFS_W-1:0] OFS_ONE = {{(OFS_W-1){1'b0}}, 1'b1};
    localparam logic [AW:0]      PTR_ONE = {{AW{1'b0}}, 1'b1};

    function automatic logic [2:0] low_idx(input logic [7:0] m);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    logic [OFS_W-1:0] cnt_q, cnt_d;
    logic [MATCH_LAT-1:0] en_dly_q;
    logic [OFS_W-1:0] tag_dly_q [MATCH_LAT];
    logic [7:0]       mask_q [FIFO_DEPTH];
    logic [OFS_W-1:0] ftag_q [FIFO_DEPTH];
    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic             overflow_q;

    logic [AW-1:0] wr_idx_s, rd_idx_s;
    logic          empty_s, full_s;
    logic [7:0]    head_mask_s, head_bit_s;
    logic          accept_s, pop_s, wr_req_s, wr_s, drop_s;

    // Byte counter next state
    always_comb begin
        cnt_d = cnt_q;
        if (sod && en) begin
            cnt_d = OFS_ONE;
        end else if (en) begin
            cnt_d = cnt_q + OFS_ONE;
        end else if (sod) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Byte counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    // Delay line aligning en and the pre-update offset tag with the engine match output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_dly_q <= '0;
            for (int k = 0; k < MATCH_LAT; k++) tag_dly_q[k] <= '0;
        end else begin
            en_dly_q[0]  <= en;
            tag_dly_q[0] <= cnt_q;
            for (int k = 1; k < MATCH_LAT; k++) begin
                en_dly_q[k]  <= en_dly_q[k-1];
                tag_dly_q[k] <= tag_dly_q[k-1];
            end
        end
    end

    assign wr_idx_s    = wr_ptr_q[AW-1:0];
    assign rd_idx_s    = rd_ptr_q[AW-1:0];
    assign empty_s     = (wr_ptr_q == rd_ptr_q);
    assign full_s      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx_s == rd_idx_s);
    assign head_mask_s = mask_q[rd_idx_s];
    // Two's-complement trick isolates the lowest set engine bit.
    assign head_bit_s  = head_mask_s & (~head_mask_s + 8'd1);
    assign accept_s    = !empty_s && rpt_ready;
    assign pop_s       = accept_s && ((head_mask_s & ~head_bit_s) == 8'd0);
    assign wr_req_s    = en_dly_q[MATCH_LAT-1] && (match != 8'd0);
    assign wr_s        = wr_req_s && (!full_s || pop_s);
    assign drop_s      = wr_req_s && full_s && !pop_s;

    // FIFO storage, pointers and sticky overflow; a write into the slot being
    // popped is ordered after the head clear so the new vector wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mask_q[i] <= 8'd0;
                ftag_q[i] <= '0;
            end
        end else begin
            if (accept_s) mask_q[rd_idx_s] <= head_mask_s & ~head_bit_s;
            if (wr_s) begin
                mask_q[wr_idx_s] <= match;
                ftag_q[wr_idx_s] <= tag_dly_q[MATCH_LAT-1];
                wr_ptr_q         <= wr_ptr_q + PTR_ONE;
            end
            if (pop_s)  rd_ptr_q   <= rd_ptr_q + PTR_ONE;
            if (drop_s) overflow_q <= 1'b1;
        end
    end

`ifdef MATCH_DROP_CNT_EN
    logic [15:0] drop_cnt_q;

    // Saturating count of dropped vectors
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt_q <= 16'd0;
        end else if (drop_s && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

    // Report outputs decoded purely from registered head state
    always_comb begin
        rpt_valid = !empty_s;
        busy      = !empty_s;
        overflow  = overflow_q;
        if (!empty_s) begin
            rpt_id  = low_idx(head_mask_s);
            rpt_ofs = ftag_q[rd_idx_s];
        end else begin
            rpt_id  = 3'd0;
            rpt_ofs = '0;
        end
    end

endmodule

// File: tb/tb_match_report_queue.sv
// Self-checking bench for match_report_queue against a queue-based reference model.
module tb_match_report_queue;

    localparam int LAT   = 2;
    localparam int DEPTH = 8;
    localparam int OW    = 16;

    logic          clk = 1'b0;
    logic          rst, sod, en, rpt_ready;
    logic [7:0]    match;
    logic          rpt_valid, overflow, busy;
    logic [2:0]    rpt_id;
    logic [OW-1:0] rpt_ofs;
`ifdef MATCH_DROP_CNT_EN
    logic [15:0]   drop_cnt;
`endif

    match_report_queue #(.MATCH_LAT(LAT), .FIFO_DEPTH(DEPTH), .OFS_W(OW)) dut (
        .clk(clk), .rst(rst), .sod(sod), .en(en), .match(match),
        .rpt_valid(rpt_valid), .rpt_ready(rpt_ready), .rpt_id(rpt_id),
        .rpt_ofs(rpt_ofs), .overflow(overflow), .busy(busy)
`ifdef MATCH_DROP_CNT_EN
        , .drop_cnt(drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]    mask;
        logic [OW-1:0] tag;
    } vec_t;

    vec_t          m_fifo[$];
    logic          m_dly_en[$];
    logic [OW-1:0] m_dly_tag[$];
    int unsigned   m_cnt;
    logic          m_ovf;
    int            m_drops;
    int            n_tests = 0;
    int            n_fail  = 0;

    function automatic int low_bit(input logic [7:0] m);
        for (int i = 0; i < 8; i++) if (m[i]) return i;
        return 0;
    endfunction

    task automatic model_reset();
        m_fifo.delete();
        m_dly_en.delete();
        m_dly_tag.delete();
        for (int i = 0; i < LAT; i++) begin
            m_dly_en.push_back(1'b0);
            m_dly_tag.push_back('0);
        end
        m_cnt = 0; m_ovf = 1'b0; m_drops = 0;
    endtask

    // Drive one cycle (entered just after a falling edge), advance the model, return at next falling edge.
    task automatic cycle(input logic s, input logic e, input logic [7:0] m, input logic r);
        logic q_en; logic [OW-1:0] q_tag; vec_t v;
        sod = s; en = e; match = m; rpt_ready = r;
        q_en  = m_dly_en.pop_front();
        q_tag = m_dly_tag.pop_front();
        if (m_fifo.size() > 0 && r) begin
            v = m_fifo[0];
            v.mask[low_bit(v.mask)] = 1'b0;
            if (v.mask == 8'd0) void'(m_fifo.pop_front());
            else m_fifo[0] = v;
        end
        if (q_en && m != 8'd0) begin
            if (m_fifo.size() < DEPTH) begin
                v.mask = m; v.tag = q_tag;
                m_fifo.push_back(v);
            end else begin
                m_ovf = 1'b1;
                if (m_drops < 65535) m_drops++;
            end
        end
        m_dly_en.push_back(e);
        m_dly_tag.push_back(OW'(m_cnt));
        if (s && e)  m_cnt = 1;
        else if (e)  m_cnt = (m_cnt + 1) % (1 << OW);
        else if (s)  m_cnt = 0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; sod = 1'b0; en = 1'b0; match = 8'd0; rpt_ready = 1'b0;
        @(negedge clk);
        n_tests++; if (rpt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", rpt_valid); end
        n_tests++; if (rpt_id !== 3'd0) begin n_fail++; $display("FAIL reset_id got %0d want 0", rpt_id); end
        n_tests++; if (rpt_ofs !== 16'd0) begin n_fail++; $display("FAIL reset_ofs got %h want 0", rpt_ofs); end
        n_tests++; if (busy !== 1'b0 || overflow !== 1'b0) begin n_fail++; $display("FAIL reset_busy_ovf got %b%b want 00", busy, overflow); end
`ifdef MATCH_DROP_CNT_EN
        n_tests++; if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_drop got %0d want 0", drop_cnt); end
`endif
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_basic();
        for (int c = 0; c <= 2 + LAT; c++)
            cycle(c == 0, c <= 4, (c == 2 + LAT) ? 8'h05 : 8'h00, 1'b0);
        n_tests++; if (rpt_valid !== 1'b1 || rpt_id !== 3'd0 || rpt_ofs !== 16'd2) begin
            n_fail++; $display("FAIL basic_first got v%b id%0d ofs%0d want v1 id0 ofs2", rpt_valid, rpt_id, rpt_ofs); end
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        n_tests++; if (rpt_valid !== 1'b1 || rpt_id !== 3'd2 || rpt_ofs !== 16'd2) begin
            n_fail++; $display("FAIL basic_second got v%b id%0d ofs%0d want v1 id2 ofs2", rpt_valid, rpt_id, rpt_ofs); end
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        n_tests++; if (rpt_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL basic_empty got v%b busy%b want 0 0", rpt_valid, busy); end
    endtask

    task automatic test_stall();
        cycle(1'b0, 1'b1, 8'h00, 1'b0);
        for (int c = 1; c < LAT; c++) cycle(1'b0, 1'b0, 8'h00, 1'b0);
        cycle(1'b0, 1'b0, 8'h06, 1'b0);
        for (int c = 0; c < 5; c++) begin
            n_tests++; if (rpt_valid !== 1'b1 || busy !== 1'b1 || rpt_id !== 3'd1 || rpt_ofs !== 16'd5) begin
                n_fail++; $display("FAIL stall_hold c%0d got v%b b%b id%0d ofs%0d want v1 b1 id1 ofs5", c, rpt_valid, busy, rpt_id, rpt_ofs); end
            cycle(1'b0, 1'b0, 8'h00, 1'b0);
        end
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        n_tests++; if (rpt_valid !== 1'b1 || rpt_id !== 3'd2 || rpt_ofs !== 16'd5) begin
            n_fail++; $display("FAIL stall_next got v%b id%0d ofs%0d want v1 id2 ofs5", rpt_valid, rpt_id, rpt_ofs); end
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stall_drained busy got %b want 0", busy); end
    endtask

    task automatic test_full_pop();
        int cnt;
        for (int c = 0; c < DEPTH + LAT; c++)
            cycle(1'b0, c < DEPTH, (c >= LAT) ? 8'h01 : 8'h00, 1'b0);
        cycle(1'b0, 1'b1, 8'h00, 1'b0);
        for (int c = 1; c < LAT; c++) cycle(1'b0, 1'b0, 8'h00, 1'b0);
        cycle(1'b0, 1'b0, 8'h01, 1'b1);
        n_tests++; if (overflow !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL fullpop_ovf got ovf%b busy%b want 0 1", overflow, busy); end
        cnt = 0;
        for (int k = 0; k < 4 * DEPTH && rpt_valid; k++) begin
            n_tests++; if (rpt_id !== 3'(low_bit(m_fifo[0].mask)) || rpt_ofs !== m_fifo[0].tag) begin
                n_fail++; $display("FAIL fullpop_rpt got id%0d ofs%0d want id%0d ofs%0d", rpt_id, rpt_ofs, low_bit(m_fifo[0].mask), m_fifo[0].tag); end
            cycle(1'b0, 1'b0, 8'h00, 1'b1);
            cnt++;
        end
        n_tests++; if (cnt !== DEPTH || rpt_valid !== 1'b0) begin
            n_fail++; $display("FAIL fullpop_count got %0d reports v%b want %0d v0", cnt, rpt_valid, DEPTH); end
    endtask

    task automatic test_wrap();
        cycle(1'b1, 1'b0, 8'h00, 1'b0);
        repeat (65535) cycle(1'b0, 1'b1, 8'h00, 1'b0);
        for (int c = 0; c <= 1 + LAT; c++)
            cycle(1'b0, c < 2, (c == 1 + LAT) ? 8'h10 : 8'h00, 1'b0);
        n_tests++; if (rpt_valid !== 1'b1 || rpt_id !== 3'd4 || rpt_ofs !== 16'h0000) begin
            n_fail++; $display("FAIL wrap_tag got v%b id%0d ofs%h want v1 id4 ofs0000", rpt_valid, rpt_id, rpt_ofs); end
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wrap_drain busy got %b want 0", busy); end
    endtask

    task automatic test_overflow();
        int cnt;
        for (int c = 0; c <= DEPTH + LAT; c++)
            cycle(1'b0, c <= DEPTH, (c >= LAT) ? 8'h01 : 8'h00, 1'b0);
        n_tests++; if (overflow !== 1'b1 || busy !== 1'b1) begin
            n_fail++; $display("FAIL ovf_flag got ovf%b busy%b want 1 1", overflow, busy); end
`ifdef MATCH_DROP_CNT_EN
        n_tests++; if (drop_cnt !== 16'd1) begin n_fail++; $display("FAIL ovf_dropcnt got %0d want 1", drop_cnt); end
`endif
        cnt = 0;
        for (int k = 0; k < 4 * DEPTH && rpt_valid; k++) begin
            n_tests++; if (rpt_id !== 3'd0 || rpt_ofs !== m_fifo[0].tag) begin
                n_fail++; $display("FAIL ovf_rpt got id%0d ofs%0d want id0 ofs%0d", rpt_id, rpt_ofs, m_fifo[0].tag); end
            cycle(1'b0, 1'b0, 8'h00, 1'b1);
            cnt++;
        end
        n_tests++; if (cnt !== DEPTH || overflow !== 1'b1) begin
            n_fail++; $display("FAIL ovf_count got %0d stored ovf%b want %0d ovf1", cnt, overflow, DEPTH); end
    endtask

    task automatic test_random();
        logic [7:0] m;
        for (int k = 0; k < 800; k++) begin
            n_tests++; if (rpt_valid !== (m_fifo.size() > 0) || busy !== (m_fifo.size() > 0) || overflow !== m_ovf) begin
                n_fail++; $display("FAIL rand_flags k%0d got v%b b%b o%b want v%b o%b", k, rpt_valid, busy, overflow, m_fifo.size() > 0, m_ovf); end
            if (m_fifo.size() > 0) begin
                n_tests++; if (rpt_id !== 3'(low_bit(m_fifo[0].mask)) || rpt_ofs !== m_fifo[0].tag) begin
                    n_fail++; $display("FAIL rand_rpt k%0d got id%0d ofs%0d want id%0d ofs%0d", k, rpt_id, rpt_ofs, low_bit(m_fifo[0].mask), m_fifo[0].tag); end
            end
`ifdef MATCH_DROP_CNT_EN
            n_tests++; if (drop_cnt !== 16'(m_drops)) begin n_fail++; $display("FAIL rand_drop got %0d want %0d", drop_cnt, m_drops); end
`endif
            m = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
            cycle($urandom_range(0, 15) == 0, $urandom_range(0, 9) < 7, m, $urandom_range(0, 9) < 5);
        end
        for (int k = 0; k < 10 * DEPTH && rpt_valid; k++) cycle(1'b0, 1'b0, 8'h00, 1'b1);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rand_drain busy got %b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c <= 2 + LAT; c++)
            cycle(1'b0, c < 3, (c >= LAT) ? 8'(c + 1) : 8'h00, 1'b0);
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst_pending busy got %b want 1", busy); end
        #2 rst = 1'b1;
        #1;
        n_tests++; if (rpt_valid !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL midrst_async got v%b b%b o%b want 0 0 0", rpt_valid, busy, overflow); end
        n_tests++; if (rpt_id !== 3'd0 || rpt_ofs !== 16'd0) begin
            n_fail++; $display("FAIL midrst_zero got id%0d ofs%0d want 0 0", rpt_id, rpt_ofs); end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < 3; c++) begin
            cycle(1'b0, 1'b0, 8'h00, 1'b1);
            n_tests++; if (rpt_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_quiet got v%b want 0", rpt_valid); end
        end
        cycle(1'b0, 1'b1, 8'h00, 1'b1);
        for (int c = 1; c < LAT; c++) cycle(1'b0, 1'b0, 8'h00, 1'b1);
        cycle(1'b0, 1'b0, 8'h80, 1'b1);
        n_tests++; if (rpt_valid !== 1'b1 || rpt_id !== 3'd7 || rpt_ofs !== 16'd0) begin
            n_fail++; $display("FAIL midrst_new got v%b id%0d ofs%0d want v1 id7 ofs0", rpt_valid, rpt_id, rpt_ofs); end
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_drain busy got %b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_full_pop();
        test_wrap();
        test_overflow();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
